// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word array, byte-lane writes, programmable wait states, two-cycle ERROR.
// Define AHB_SRAM_ZERO_INIT_EN to clear the array one word per cycle after every reset.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
`ifdef AHB_SRAM_ZERO_INIT_EN
    S_INIT,
`endif
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [3:0]              r_cnt;
  logic [3:0]              w_nextCnt;
  logic                    r_phValid;
  logic                    r_phWrite;
  logic                    r_phErr;
  logic [2:0]              r_phSize;
  logic [IDX_W+1:0]        r_phAddr;
  logic [IDX_W-1:0]        w_phIdx;
  logic                    w_accept;
  logic                    w_accErr;
  logic                    w_start;
  logic                    w_startErr;
  logic                    w_hreadyout;
  logic [1:0]              w_hresp;
  logic                    w_we;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];
`ifdef AHB_SRAM_ZERO_INIT_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);
  logic [IDX_W-1:0]        r_initIdx;
`endif

  assign w_accept = hsel && hready && htrans[1];
  assign w_accErr = (haddr >= MEM_BYTES) || (hsize > 3'b010) ||
                    ((hsize == 3'b001) && haddr[0]) ||
                    ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  assign w_phIdx  = r_phAddr[IDX_W+1:2];

  // Ready/response depend only on registered state so the bus hready loop stays acyclic.
  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = 2'b00;
    unique case (r_state)
`ifdef AHB_SRAM_ZERO_INIT_EN
      S_INIT: w_hreadyout = !r_phValid;
`endif
      S_WAIT: w_hreadyout = 1'b0;
      S_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 2'b01;
      end
      S_ERR2: w_hresp = 2'b01;
      default: w_hreadyout = 1'b1;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_start     = 1'b0;
    w_startErr  = 1'b0;
    unique case (r_state)
`ifdef AHB_SRAM_ZERO_INIT_EN
      S_INIT: begin
        // A transfer parked during the clear is dispatched on the last clearing edge.
        if (r_initIdx == LAST_IDX) begin
          w_nextState = S_IDLE;
          w_start     = r_phValid || w_accept;
          w_startErr  = r_phValid ? r_phErr : w_accErr;
        end
      end
`endif
      S_IDLE: begin
        w_start    = w_accept;
        w_startErr = w_accErr;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_nextState = S_IDLE;
        else               w_nextCnt   = r_cnt - 4'd1;
      end
      S_ERR1: w_nextState = S_ERR2;
      S_ERR2: begin
        w_nextState = S_IDLE;
        w_start     = w_accept;
        w_startErr  = w_accErr;
      end
      default: w_nextState = S_IDLE;
    endcase
    if (w_start) begin
      if (w_startErr) begin
        w_nextState = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        w_nextState = S_WAIT;
        w_nextCnt   = CNT_LOAD;
      end else begin
        w_nextState = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef AHB_SRAM_ZERO_INIT_EN
      r_state <= S_INIT;
`else
      r_state <= S_IDLE;
`endif
      r_cnt <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

`ifdef AHB_SRAM_ZERO_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_initIdx <= '0;
    else if (r_state == S_INIT) r_initIdx <= r_initIdx + 1'b1;
  end
`endif

  // The address phase only advances on edges where the current data phase completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phValid <= 1'b0;
      r_phWrite <= 1'b0;
      r_phErr   <= 1'b0;
      r_phSize  <= 3'b000;
      r_phAddr  <= '0;
    end else if (hready && w_hreadyout) begin
      r_phValid <= w_accept;
      r_phWrite <= hwrite;
      r_phErr   <= w_accErr;
      r_phSize  <= hsize;
      r_phAddr  <= haddr[IDX_W+1:0];
    end
  end

  always_comb begin
    w_be = 4'b0000;
    unique case (r_phSize)
      3'b000:  w_be[r_phAddr[1:0]] = 1'b1;
      3'b001:  w_be = r_phAddr[1] ? 4'b1100 : 4'b0011;
      3'b010:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_we = r_phValid && r_phWrite && !r_phErr && w_hreadyout;

  always_ff @(posedge clk) begin
`ifdef AHB_SRAM_ZERO_INIT_EN
    if (r_state == S_INIT) r_mem[r_initIdx] <= '0;
`endif
    if (w_we) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_phIdx][8*l +: 8] <= hwdata[8*l +: 8];
      end
    end
  end

  assign hreadyout = w_hreadyout;
  assign hresp     = w_hresp;
  assign hrdata    = (r_phValid && !r_phWrite && !r_phErr && w_hreadyout) ?
                     r_mem[w_phIdx] : '0;

endmodule
